// File: rtl/mem_stage_if.sv
// Data-bus bundle between the memory stage and the data memory.
// One request at a time, completed by a single-cycle acknowledge.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [XLEN/8-1:0] mem_wstrb_o;
    logic              mem_ack_i;
    logic [XLEN-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o,
        output mem_wdata_o, mem_wstrb_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o,
        input  mem_wdata_o, mem_wstrb_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one load/store per instruction,
// load formatting, and a held result for the W-pipe.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            e_valid_i,
    output logic            M_ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] npc_i,
    input  logic [XLEN-1:0] res_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [1:0]      mem_size_i,
    input  logic            mem_unsigned_i,
    input  logic [4:0]      rd_i,
    input  logic            rd_wen_i,
    mem_stage_if.master     bus,
    output logic            m_valid_o,
    input  logic            W_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] npc_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      rd_o,
    output logic            rd_wen_o
);
    localparam int SW = XLEN / 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    logic [1:0]      state_q;
    logic [XLEN-1:0] pc_q, npc_q, addr_q, src2_q, wb_q;
    logic            ld_q, st_q, uns_q, rd_wen_q;
    logic [1:0]      size_q;
    logic [4:0]      rd_q;

    logic            busy, full, accept;
    logic            sz_b, sz_h, sz_w;
    logic [1:0]      a;
    logic [XLEN-1:0] wdata, sh, ld_data;
    logic [SW-1:0]   strb;

    assign busy   = (state_q == BUSY);
    assign full   = (state_q == FULL);
    assign accept = e_valid_i & M_ready_o;

    assign M_ready_o = (state_q == IDLE) | (full & W_ready_i);
    assign m_valid_o = full;

    assign a    = addr_q[1:0];
    assign sz_b = (size_q == 2'd0);
    assign sz_h = (size_q == 2'd1);
    assign sz_w = size_q[1];

    // Lane steering shared by store data/strobes and load extraction.
    always_comb begin
        wdata   = src2_q;
        strb    = '0;
        sh      = bus.mem_rdata_i;
        ld_data = bus.mem_rdata_i;
        unique case (1'b1)
            sz_b: begin
                wdata   = {SW{src2_q[7:0]}};
                strb    = SW'(1) << a;
                sh      = bus.mem_rdata_i >> {a, 3'b000};
                ld_data = {{(XLEN-8){~uns_q & sh[7]}}, sh[7:0]};
            end
            sz_h: begin
                wdata   = {(SW/2){src2_q[15:0]}};
                strb    = SW'(3) << {a[1], 1'b0};
                sh      = bus.mem_rdata_i >> {a[1], 4'b0000};
                ld_data = {{(XLEN-16){~uns_q & sh[15]}}, sh[15:0]};
            end
            sz_w: begin
                strb = '1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req_o   = busy;
    assign bus.mem_we_o    = busy & st_q;
    assign bus.mem_addr_o  = {addr_q[XLEN-1:2], 2'b00};
    assign bus.mem_wdata_o = wdata;
    assign bus.mem_wstrb_o = (busy & st_q) ? strb : '0;

    assign pc_o      = pc_q;
    assign npc_o     = npc_q;
    assign wb_data_o = wb_q;
    assign rd_o      = rd_q;
    assign rd_wen_o  = rd_wen_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            npc_q    <= '0;
            addr_q   <= '0;
            src2_q   <= '0;
            wb_q     <= '0;
            ld_q     <= 1'b0;
            st_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'd0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
        end else if (accept) begin
            pc_q     <= pc_i;
            npc_q    <= npc_i;
            addr_q   <= res_i;
            src2_q   <= src2_i;
            wb_q     <= res_i;
            ld_q     <= is_load_i;
            st_q     <= is_store_i;
            uns_q    <= mem_unsigned_i;
            size_q   <= mem_size_i;
            rd_q     <= rd_i;
            rd_wen_q <= rd_wen_i & ~is_store_i;
            state_q  <= (is_load_i | is_store_i) ? BUSY : FULL;
        end else if (busy && bus.mem_ack_i) begin
            state_q <= FULL;
            if (ld_q) begin
                wb_q <= ld_data;
            end
        end else if (full && W_ready_i) begin
            state_q <= IDLE;
        end
    end
endmodule
